// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: loads two WIDTH-bit operands and a carry-in on
// start, adds one bit pair per clock LSB-first through a 1-bit full adder, and
// publishes the registered sum/carry-out with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_sr, a_sr_d;
  logic [WIDTH-1:0] b_sr, b_sr_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic             carry, carry_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             busy_d, done_d, cout_d;
  logic [WIDTH-1:0] s_d;

  logic sum_bit_c;
  logic maj_c;
  logic load_c;

  // Full-adder stage on the current LSB pair and recirculated carry
  always_comb begin
    sum_bit_c = a_sr[0] ^ b_sr[0] ^ carry;
    maj_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  end

  // Next-state and next-output logic; done defaults low so it pulses once
  always_comb begin
    state_d = state;
    a_sr_d  = a_sr;
    b_sr_d  = b_sr;
    acc_d   = acc;
    carry_d = carry;
    cnt_d   = cnt;
    busy_d  = busy;
    done_d  = 1'b0;
    s_d     = s;
    cout_d  = cout;
    load_c  = 1'b0;

    case (state)
      IDLE: begin
        if (start) load_c = 1'b1;
      end
      ADD: begin
        carry_d = maj_c;
        acc_d   = (acc >> 1) | (WIDTH'(sum_bit_c) << (WIDTH - 1));
        a_sr_d  = a_sr >> 1;
        b_sr_d  = b_sr >> 1;
        cnt_d   = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          s_d     = (acc >> 1) | (WIDTH'(sum_bit_c) << (WIDTH - 1));
          cout_d  = maj_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) load_c = 1'b1;
        else       state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operand capture shared by IDLE and back-to-back restart from DONE
    if (load_c) begin
      a_sr_d  = a;
      b_sr_d  = b;
      carry_d = cin;
      cnt_d   = '0;
      acc_d   = '0;
      busy_d  = 1'b1;
      state_d = ADD;
    end
  end

  // State and output registers, cleared asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_d;
      a_sr  <= a_sr_d;
      b_sr  <= b_sr_d;
      acc   <= acc_d;
      carry <= carry_d;
      cnt   <= cnt_d;
      busy  <= busy_d;
      done  <= done_d;
      s     <= s_d;
      cout  <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  typedef struct packed {
    logic [7:0]  s;
    logic        cout;
    logic [31:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin8 = 1'b0, cin1 = 1'b0;
  logic       busy8, done8, cout8, busy1, done1, cout1;
  logic [7:0] s8;
  logic [0:0] s1;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb8[$];
  exp_t sb1[$];
  logic prev_done8 = 1'b0, prev_done1 = 1'b0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor for the 8-bit instance
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      exp_t e;
      check("done8_single_cycle", 32'(prev_done8), 32'd0);
      if (sb8.size() == 0) begin
        check("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb8.pop_front();
        check("s8", 32'(s8), 32'(e.s));
        check("cout8", 32'(cout8), 32'(e.cout));
        check("latency8", 32'(cyc), e.cyc);
      end
    end
    prev_done8 = done8;
  end

  // Result monitor for the 1-bit instance
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      exp_t e;
      check("done1_single_cycle", 32'(prev_done1), 32'd0);
      if (sb1.size() == 0) begin
        check("done1_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb1.pop_front();
        check("s1", 32'(s1), 32'(e.s));
        check("cout1", 32'(cout1), 32'(e.cout));
        check("latency1", 32'(cyc), e.cyc);
      end
    end
    prev_done1 = done1;
  end

  // Issue one operation on the 8-bit instance once it can accept; returns at
  // the falling edge following the accepting edge
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input int gap);
    logic [8:0] sum;
    int n;
    exp_t e;
    repeat (gap) @(negedge clk);
    n = 0;
    @(negedge clk);
    while (busy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("op8_wait_timeout", 32'(n), 32'd0);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    sum = 9'(ta) + 9'(tb) + 9'(tc);
    e.s = sum[7:0]; e.cout = sum[8]; e.cyc = 32'(cyc + 1 + 8);
    sb8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic op1(input logic ta, input logic tb, input logic tc, input int gap);
    logic [1:0] sum;
    int n;
    exp_t e;
    repeat (gap) @(negedge clk);
    n = 0;
    @(negedge clk);
    while (busy1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("op1_wait_timeout", 32'(n), 32'd0);
    a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
    sum = 2'(ta) + 2'(tb) + 2'(tc);
    e.s = {7'd0, sum[0]}; e.cout = sum[1]; e.cyc = 32'(cyc + 1 + 1);
    sb1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
  endtask

  task automatic wait_done8(input string tag);
    int n = 0;
    while (done8 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check(tag, 32'(n), 32'd0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb8.size() != 0 || sb1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sb8.size() + sb1.size()), 32'd0);
  endtask

  initial begin
    // Reset held for 3 cycles, then idle for 10
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", 32'({busy8, busy1}), 32'd0);
      check("rst_done", 32'({done8, done1}), 32'd0);
      check("rst_s", 32'({s8, s1}), 32'd0);
      check("rst_cout", 32'({cout8, cout1}), 32'd0);
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_outputs", 32'({busy8, done8, s8, cout8}), 32'd0);
    end

    // FF + 01: busy across the 8 add cycles, then a single done pulse
    op8(8'hFF, 8'h01, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      check("ff01_busy", 32'(busy8), 32'd1);
      check("ff01_no_done", 32'(done8), 32'd0);
      @(negedge clk);
    end
    check("ff01_busy_end", 32'(busy8), 32'd0);
    check("ff01_done", 32'(done8), 32'd1);
    @(negedge clk);
    check("ff01_done_drop", 32'(done8), 32'd0);

    // 5A + 25 + 1: previous 00/1 must stay visible until completion
    op8(8'h5A, 8'h25, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      check("hold_s", 32'(s8), 32'h00);
      check("hold_cout", 32'(cout8), 32'd1);
      @(negedge clk);
    end
    check("5a25_done", 32'(done8), 32'd1);

    // Back-to-back with start held high throughout
    begin
      exp_t e;
      @(negedge clk);
      a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; start8 = 1'b1;
      e.s = 8'h07; e.cout = 1'b0; e.cyc = 32'(cyc + 1 + 8);
      sb8.push_back(e);
      @(negedge clk);
      a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
      e.s = 8'h00; e.cout = 1'b1; e.cyc = 32'(cyc + 17);
      sb8.push_back(e);
      wait_done8("b2b_first_timeout");
      @(negedge clk);
      check("b2b_reload_busy", 32'(busy8), 32'd1);
      start8 = 1'b0;
      a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
      wait_done8("b2b_second_timeout");
      @(negedge clk);
    end

    // Reset in the middle of an addition abandons it
    op8(8'hAA, 8'h55, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    sb8.delete();
    sb1.delete();
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_s", 32'(s8), 32'd0);
    check("midrst_cout", 32'(cout8), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("midrst_idle", 32'({busy8, done8}), 32'd0);
    end
    op8(8'h01, 8'h01, 1'b0, 0);
    drain("after_rst_drain");

    // Random sweeps on both widths
    for (int i = 0; i < 250; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    drain("rand8_drain");
    for (int i = 0; i < 250; i++)
      op1(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    drain("rand1_drain");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that feeds one operand bit pair per clock into a single-bit full-adder datapath and collects the sum bits. It accepts two WIDTH-bit operands and a carry-in on a start pulse, then iterates LSB-first for WIDTH cycles. It presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits directly around the 1-bit full-adder stage: upstream it loads and shifts operand bits and recirculates carry, and downstream it consumes the sum bits.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a new addition; sampled on rising clk edge
a  input  WIDTH  operand A; captured when start is accepted
b  input  WIDTH  operand B; captured when start is accepted
cin  input  1  carry-in; captured when start is accepted
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse: s/cout are valid
s  output  WIDTH  registered sum; held until the next completion
cout  output  1  registered carry-out; held until the next completion

Behaviour:
- Interface (decided): single clock clk. reset is asynchronous and active-high. All state is cleared immediately on reset assertion, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, s=0, cout=0. Internal shift registers, carry flop and bit counter are all 0.
- States: IDLE, ADD, DONE.
- IDLE: with start=1 at edge E0:
  - a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, acc<=0.
  - Go to ADD; busy=1 from E0.
  - With start=0: stay in IDLE.
- ADD, each edge:
  - bit = a_sr[0]^b_sr[0]^carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - acc shifts right with bit entering the MSB; a_sr and b_sr shift right.
  - cnt <= cnt+1.
- ADD, on the edge where cnt==WIDTH-1 (edge E_WIDTH):
  - s <= final acc value, including this bit; cout <= final carry.
  - done<=1, busy<=0; go to DONE.
- DONE lasts exactly one cycle.
  - At the next edge done<=0.
  - With start=0: go to IDLE.
  - With start=1: load the new operands exactly as in IDLE (back-to-back operation); busy=1, state ADD.
- Latency: start sampled at E0 -> done high during the cycle after E_WIDTH (WIDTH edges later). Throughput is one result per WIDTH+1 cycles.
- start while in ADD is ignored; there is no queuing. a/b/cin changes during ADD have no effect.
- s/cout change only on the completion edge or on reset. The previous result stays visible throughout a subsequent addition.
- Arithmetic: {cout,s} = a + b + cin, modulo 2^(WIDTH+1); unsigned.
- cnt is ceil(log2(WIDTH))+1 bits wide and never wraps within an operation.
- WIDTH=1: ADD lasts a single edge; done is high in the cycle after E1.
- Reset asserted mid-ADD: the operation is abandoned, all outputs return to reset values, and no done pulse is produced. After deassertion the block waits in IDLE for start.
- Reset asserted during DONE: done drops immediately (asynchronous).

Test Plan:
- Reset then idle: hold reset 3 cycles, release, start=0 for 10 cycles -> busy=0, done=0, s=0, cout=0 throughout.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulse at E0 -> busy high E0..E8; done=1 for exactly one cycle after E8; s=8'h00, cout=1.
- WIDTH=8, a=8'h5A, b=8'h25, cin=1 -> s=8'h80, cout=0. Previous result (8'h00/1) stays held on s/cout until E8.
- Back-to-back: start held high continuously, alternating operands (3+4+0, then 8'hF0+8'h0F+1) -> results 8'h07/0 then 8'h00/1. Second done arrives 9 cycles after the first; start pulses during ADD are ignored.
- Reset mid-op: start 8'hAA+8'h55, assert reset at E4 -> busy, done, s, cout go to 0 immediately with no done pulse. After release, start 8'h01+8'h01+0 -> s=8'h02, cout=0.
- Randomized sweep with WIDTH=1 and WIDTH=8, 500 operations with random gaps, compared against a + b + cin -> all match; done latency is exactly WIDTH edges after the accepting edge.
